// File: rtl/max_pool_2x2_pkg.sv
// Shared lane width and signed 8-bit max helper for the 2x2 max-pool stage.
package max_pool_2x2_pkg;

    localparam int unsigned DATA_W = 8;

    function automatic logic [DATA_W-1:0] max_s8(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_lanes.sv
// Combinational per-lane signed max of two packed SIZE-lane buses.
module max_pool_lanes
    import max_pool_2x2_pkg::*;
#(
    parameter int unsigned SIZE = 4
) (
    input  logic [DATA_W*SIZE-1:0] a_i,
    input  logic [DATA_W*SIZE-1:0] b_i,
    output logic [DATA_W*SIZE-1:0] max_o
);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        assign max_o[DATA_W*i +: DATA_W] = max_s8(a_i[DATA_W*i +: DATA_W],
                                                  b_i[DATA_W*i +: DATA_W]);
    end

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max pool with a half-row line buffer.
// Define MAX_POOL_LAST_EN to add out_last, flagging the final pooled pixel of a frame.
module max_pool_2x2
    import max_pool_2x2_pkg::*;
#(
    parameter int unsigned SIZE   = 4,
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned HEIGHT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_W*SIZE-1:0] in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W*SIZE-1:0] out,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef MAX_POOL_LAST_EN
    ,
    output logic                   out_last
`endif
);

    localparam int unsigned BusW  = DATA_W * SIZE;
    localparam int unsigned ColW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RowW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned HalfW = WIDTH / 2;
    localparam int unsigned IdxW  = (HalfW > 1) ? $clog2(HalfW) : 1;

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [BusW-1:0] hold_q, hold_d;
    logic [BusW-1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic [BusW-1:0] linebuf_q [HalfW];

    logic            fire;
    logic            lb_we;
    logic            col_last;
    logic            row_last;
    logic [IdxW-1:0] lb_idx;
    logic [BusW-1:0] h_max;
    logic [BusW-1:0] v_max;

`ifdef MAX_POOL_LAST_EN
    logic last_q, last_d;
    assign out_last = last_q;
`endif

    assign in_ready  = !out_valid_q || out_ready;
    assign fire      = in_valid && in_ready;
    assign col_last  = (col_q == ColW'(WIDTH - 1));
    assign row_last  = (row_q == RowW'(HEIGHT - 1));
    assign lb_idx    = IdxW'(col_q >> 1);
    assign out       = out_q;
    assign out_valid = out_valid_q;

    max_pool_lanes #(
        .SIZE(SIZE)
    ) u_hmax (
        .a_i  (hold_q),
        .b_i  (in),
        .max_o(h_max)
    );

    max_pool_lanes #(
        .SIZE(SIZE)
    ) u_vmax (
        .a_i  (linebuf_q[lb_idx]),
        .b_i  (h_max),
        .max_o(v_max)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        lb_we       = 1'b0;
`ifdef MAX_POOL_LAST_EN
        last_d      = last_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
`ifdef MAX_POOL_LAST_EN
            last_d      = 1'b0;
`endif
        end
        // A result load overrides the clear from a same-cycle output transfer.
        if (fire) begin
            if (!col_q[0]) begin
                hold_d = in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_d       = v_max;
                out_valid_d = 1'b1;
`ifdef MAX_POOL_LAST_EN
                last_d      = row_last && col_last;
`endif
            end
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef MAX_POOL_LAST_EN
            last_q      <= 1'b0;
`endif
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef MAX_POOL_LAST_EN
            last_q      <= last_d;
`endif
        end
    end

    // Row 0 always rewrites every entry before it is read, so no reset is needed.
    always_ff @(posedge clock) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= h_max;
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: directed scenarios plus random frames vs a window model.
module tb_max_pool_2x2;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int S    = 4;
    localparam int BW   = 8 * S;
    localparam int NPIX = W * H;

    logic          clock = 1'b0;
    logic          reset;
    logic [BW-1:0] in;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] out;
    logic          out_valid;
    logic          out_ready;
`ifdef MAX_POOL_LAST_EN
    logic          out_last;
`endif

    int tests = 0;
    int fails = 0;

    logic [BW-1:0] exp_q[$];
    bit            lq[$];
    logic [BW-1:0] got[$];
    bit            got_last[$];
    logic [BW-1:0] frame [NPIX];
    logic [BW-1:0] mpix [H][W];
    logic [BW-1:0] cexp [4];

    always #5 clock = ~clock;

    max_pool_2x2 #(
        .SIZE  (S),
        .WIDTH (W),
        .HEIGHT(H)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MAX_POOL_LAST_EN
        ,
        .out_last (out_last)
`endif
    );

    // Lane-wise signed maximum of four pixels, done in plain integer arithmetic.
    function automatic logic [BW-1:0] max4(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                           input logic [BW-1:0] c, input logic [BW-1:0] d);
        logic [BW-1:0] r;
        int            m;
        int            v [4];
        r = '0;
        for (int i = 0; i < S; i++) begin
            v[0] = int'($signed(a[8*i +: 8]));
            v[1] = int'($signed(b[8*i +: 8]));
            v[2] = int'($signed(c[8*i +: 8]));
            v[3] = int'($signed(d[8*i +: 8]));
            m = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
            r[8*i +: 8] = 8'(m);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %b required %b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        tests++;
        assert (obs == expv) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    // Monitor and reference model, sampled on the falling edge.
    initial begin : monitor
        int            r;
        int            c;
        int            nbeat;
        bit            pend;
        bit            prev_stall;
        logic [BW-1:0] prev_out;
        logic [BW-1:0] e;
        bit            l;
        nbeat      = 0;
        pend       = 1'b0;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                lq.delete();
                nbeat      = 0;
                pend       = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (pend) check1("latency", out_valid, 1'b1);
                pend = 1'b0;
                if (prev_stall) begin
                    check1("stall_valid", out_valid, 1'b1);
                    check("stall_data", out, prev_out);
                end
                check1("in_ready_rule", in_ready, !out_valid || out_ready);
`ifdef MAX_POOL_LAST_EN
                if (!out_valid) check1("last_idle", out_last, 1'b0);
`endif
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $error("FAIL spurious_out: observed %h required no output", out);
                    end else begin
                        e = exp_q.pop_front();
                        l = lq.pop_front();
                        check("pool_data", out, e);
`ifdef MAX_POOL_LAST_EN
                        check1("pool_last", out_last, l);
                        got_last.push_back(out_last);
`endif
                        got.push_back(out);
                    end
                end
                if (in_valid && in_ready) begin
                    r = nbeat / W;
                    c = nbeat % W;
                    mpix[r][c] = in;
                    if ((r % 2 == 1) && (c % 2 == 1)) begin
                        exp_q.push_back(max4(mpix[r-1][c-1], mpix[r-1][c], mpix[r][c-1], in));
                        lq.push_back((r == H - 1) && (c == W - 1));
                        pend = 1'b1;
                    end
                    nbeat = (nbeat + 1) % NPIX;
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = out;
            end
        end
    end

    task automatic send_pixel(input logic [BW-1:0] px, input bit rand_bp);
        int n;
        bit acc;
        in       = px;
        in_valid = 1'b1;
        n        = 0;
        do begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            tests++;
            fails++;
            $error("FAIL send_timeout: observed no accept required accept within 200 cycles");
        end
    endtask

    task automatic send_frame(input bit rand_bp, input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clock);
                    #1;
                end
            end
            send_pixel(frame[i], rand_bp);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n         = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        @(posedge clock);
        #1;
        check1("drain_empty", (exp_q.size() == 0) && !out_valid, 1'b1);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < NPIX; i++) frame[i] = {S{8'(i)}};
    endtask

    task automatic check_ramp(input string tag);
        check_int({tag, "_count"}, got.size(), 4);
        for (int i = 0; i < 4; i++) check({tag, "_res"}, got[i], cexp[i]);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish required finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int            wr;
        int            wc;
        int            w;
        logic [BW-1:0] base;
        logic [BW-1:0] odd;
        logic [BW-1:0] e;
        cexp[0] = 32'h05050505;
        cexp[1] = 32'h07070707;
        cexp[2] = 32'h0d0d0d0d;
        cexp[3] = 32'h0f0f0f0f;

        // 1: reset held with in_valid high, then a ramp frame.
        reset     = 1'b1;
        in        = 32'hdeadbeef;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        check("rst_out", out, '0);
        check1("rst_valid", out_valid, 1'b0);
        check1("rst_in_ready", in_ready, 1'b1);
`ifdef MAX_POOL_LAST_EN
        check1("rst_last", out_last, 1'b0);
`endif
        repeat (2) @(posedge clock);
        #1;
        check1("rst_valid_held", out_valid, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b0;
        load_ramp();
        got.delete();
        got_last.delete();
        send_frame(1'b0, 1'b0);
        drain();
        check_ramp("s1");
`ifdef MAX_POOL_LAST_EN
        for (int i = 0; i < 4; i++) check1("s6_last", got_last[i], (i == 3));
`endif

        // 2: signed compare, odd pixel in a different window position each time.
        base = 32'hf010807f;
        odd  = 32'h0100817e;
        for (int p = 0; p < NPIX; p++) begin
            wr = (p / W) / 2;
            wc = (p % W) / 2;
            w  = wr * 2 + wc;
            frame[p] = (((p / W) % 2) * 2 + (p % W) % 2 == w) ? odd : base;
        end
        got.delete();
        send_frame(1'b0, 1'b0);
        drain();
        check_int("s2_count", got.size(), 4);
        for (int i = 0; i < 4; i++) check("s2_signed", got[i], 32'h0110817f);

        // 3: backpressure on the first result.
        load_ramp();
        got.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_pixel(frame[i], 1'b0);
        in       = frame[6];
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check1("s3_valid", out_valid, 1'b1);
            check("s3_data", out, 32'h05050505);
            check1("s3_in_ready", in_ready, 1'b0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check1("s3_in_ready_back", in_ready, 1'b1);
        for (int i = 6; i < NPIX; i++) send_pixel(frame[i], 1'b0);
        in_valid = 1'b0;
        drain();
        check_ramp("s3");

        // 4: two identical random frames back to back.
        for (int i = 0; i < NPIX; i++) frame[i] = $urandom;
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * NPIX; i++) send_pixel(frame[i % NPIX], 1'b0);
        in_valid = 1'b0;
        drain();
        check_int("s4_count", got.size(), 8);
        for (int i = 0; i < 4; i++) begin
            wr = (i / 2) * 2;
            wc = (i % 2) * 2;
            e  = max4(frame[wr*W + wc], frame[wr*W + wc + 1],
                      frame[(wr+1)*W + wc], frame[(wr+1)*W + wc + 1]);
            check("s4_frame1", got[i], e);
            check("s4_frame2", got[i+4], e);
        end

        // 5: reset mid-frame clears out_valid asynchronously.
        load_ramp();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_pixel(frame[i], 1'b0);
        in_valid = 1'b0;
        check1("s5_pre_valid", out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check1("s5_async_valid", out_valid, 1'b0);
        check("s5_async_out", out, '0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        got.delete();
        send_frame(1'b0, 1'b0);
        drain();
        check_ramp("s5");

        // 7: random frames with random gaps and backpressure.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) frame[i] = $urandom;
            got.delete();
            send_frame(1'b1, 1'b1);
            drain();
            check_int("s7_count", got.size(), 4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
